axi_arbiter: RTL

- Two-master AXI-lite arbiter: IFU (master 0) and LSU (master 1) share one master port feeding the axi_xbar.
- Grants one complete transaction at a time (address -> data -> response) with round-robin fairness.
- Ungranted masters are stalled.
- Sits between the core front/back ends and the crossbar. The flattened per-master port style matches the crossbar.

---
 rtl/axi_arbiter_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 16 +
 rtl/axi_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/axi_arbiter_pkg.sv
// Shared definitions for the two-master AXI-lite arbiter.
// State encoding and master indices used across the arbiter files.
package axi_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4
    } state_t;

    localparam logic IFU = 1'b0;
    localparam logic LSU = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select.
// On a tie the master that did not win last time is chosen.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    // Pick the sole requester, or alternate on a tie
    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/axi_arbiter.sv
// AXI-lite arbiter: IFU and LSU share one downstream master port.
// One full transaction is granted at a time, round-robin between masters.
module axi_arbiter
    import axi_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_MASTERS = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
    input  logic [NUM_MASTERS-1:0]            m_arvalid,
    output logic [NUM_MASTERS-1:0]            m_arready,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    input  logic [NUM_MASTERS-1:0]            m_rready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_awaddr,
    input  logic [NUM_MASTERS-1:0]            m_awvalid,
    output logic [NUM_MASTERS-1:0]            m_awready,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS*4-1:0]          m_wstrb,
    input  logic [NUM_MASTERS-1:0]            m_wvalid,
    output logic [NUM_MASTERS-1:0]            m_wready,
    output logic [NUM_MASTERS-1:0]            m_bvalid,
    input  logic [NUM_MASTERS-1:0]            m_bready,
    output logic [ADDR_WIDTH-1:0]             s_araddr,
    output logic                              s_arvalid,
    input  logic                              s_arready,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    input  logic                              s_rvalid,
    output logic                              s_rready,
    output logic [ADDR_WIDTH-1:0]             s_awaddr,
    output logic                              s_awvalid,
    input  logic                              s_awready,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    output logic [3:0]                        s_wstrb,
    output logic                              s_wvalid,
    input  logic                              s_wready,
    input  logic                              s_bvalid,
    output logic                              s_bready
);

    state_t     state;
    logic       gnt;
    logic       last;
    logic       aw_done;
    logic       w_done;
    logic [1:0] req;
    logic       req_any;
    logic       winner;
    logic       ar_hs;
    logic       r_hs;
    logic       aw_hs;
    logic       w_hs;
    logic       b_hs;

    assign req = m_arvalid | m_awvalid;

    rr_arbiter2 u_rr (
        .req    (req),
        .last   (last),
        .valid  (req_any),
        .winner (winner)
    );

    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = s_rvalid  & s_rready;
    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid  & s_wready;
    assign b_hs  = s_bvalid  & s_bready;

    // Payload paths follow the grant; only sampled during handshakes
    always_comb begin
        s_araddr = gnt ? m_araddr[ADDR_WIDTH +: ADDR_WIDTH]
                       : m_araddr[0 +: ADDR_WIDTH];
        s_awaddr = gnt ? m_awaddr[ADDR_WIDTH +: ADDR_WIDTH]
                       : m_awaddr[0 +: ADDR_WIDTH];
        s_wdata  = gnt ? m_wdata[DATA_WIDTH +: DATA_WIDTH]
                       : m_wdata[0 +: DATA_WIDTH];
        s_wstrb  = gnt ? m_wstrb[4 +: 4] : m_wstrb[0 +: 4];
        m_rdata  = {NUM_MASTERS{s_rdata}};
    end

    // Route handshake signals between the granted master and the slave
    always_comb begin
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        unique case (state)
            RD_A: begin
                s_arvalid      = m_arvalid[gnt];
                m_arready[gnt] = s_arready;
            end
            RD_D: begin
                m_rvalid[gnt] = s_rvalid;
                s_rready      = m_rready[gnt];
            end
            WR_AW: begin
                s_awvalid      = m_awvalid[gnt] & ~aw_done;
                s_wvalid       = m_wvalid[gnt] & ~w_done;
                m_awready[gnt] = s_awready & ~aw_done;
                m_wready[gnt]  = s_wready & ~w_done;
            end
            WR_B: begin
                m_bvalid[gnt] = s_bvalid;
                s_bready      = m_bready[gnt];
            end
            default: ;
        endcase
    end

    // Transaction sequencer: arbitrate, then walk one read or write
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= IFU;
            last    <= LSU;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_any) begin
                        gnt   <= winner;
                        last  <= winner;
                        state <= m_arvalid[winner] ? RD_A : WR_AW;
                    end
                end
                RD_A: begin
                    if (ar_hs) state <= RD_D;
                end
                RD_D: begin
                    if (r_hs) state <= IDLE;
                end
                WR_AW: begin
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        state   <= WR_B;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_done | aw_hs;
                        w_done  <= w_done | w_hs;
                    end
                end
                WR_B: begin
                    if (b_hs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
